skin_segmenter: RTL
===================

# skin_segmenter

Pixel-stream skin-colour segmentation stage that sits directly downstream of `RGBtoYCbCr`. It consumes the registered `luma_ch`/`cb_ch`/`cr_ch` stream and classifies each pixel as skin or non-skin using fixed YCbCr range thresholds. It emits a one-bit mask stream with pixel coordinates, and per-frame statistics (skin pixel count and bounding box) for the later gesture-feature stages.

## Interface
Parameters:
- `IMG_W`, 320: pixels per line.
- `IMG_H`, 240: lines per frame.
- `Y_MIN`, 40: minimum luma for skin; rejects dark pixels.
- `CB_MIN`, 77: inclusive Cb lower bound.
- `CB_MAX`, 127: inclusive Cb upper bound.
- `CR_MIN`, 133: inclusive Cr lower bound.
- `CR_MAX`, 173: inclusive Cr upper bound.

Derived widths: XW = $clog2(IMG_W), YW = $clog2(IMG_H), CW = $clog2(IMG_W*IMG_H+1).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input pixel valid this cycle.
- `in_sof`  in  1  start of frame; qualified by `in_valid`; marks pixel (0,0).
- `luma_ch`  in  8  Y.
- `cb_ch`  in  8  Cb.
- `cr_ch`  in  8  Cr.
- `mask_valid`  out  1  mask output valid.
- `mask_bit`  out  1  1 = skin.
- `mask_x`  out  XW  column of the masked pixel.
- `mask_y`  out  YW  row of the masked pixel.
- `frame_done`  out  1  one-cycle pulse; statistics updated.
- `skin_count`  out  CW  skin pixels in the last completed frame.
- `bbox_valid`  out  1  last completed frame had at least one skin pixel.
- `bbox_min_x`, `bbox_max_x`  out  XW  bounding box columns.
- `bbox_min_y`, `bbox_max_y`  out  YW  bounding box rows.

## Operation
- Classification: skin = (Y ≥ Y_MIN) & (CB_MIN ≤ Cb ≤ CB_MAX) & (CR_MIN ≤ Cr ≤ CR_MAX). All compares are unsigned 8-bit and inclusive.
- FSM states:
  - IDLE: discards pixels until `in_valid & in_sof`.
  - ACTIVE: accepts pixels.
  - DONE: one cycle; publishes statistics, then returns to IDLE.
- IDLE → ACTIVE on `in_valid & in_sof`; that pixel is (0,0) and is classified.
- Coordinate counters x, y advance only on accepted `in_valid`.
  - x wraps at IMG_W-1 to 0 and increments y.
  - ACTIVE → DONE when pixel (IMG_W-1, IMG_H-1) is accepted.
- `in_sof` with `in_valid` while ACTIVE aborts the frame:
  - accumulators and counters restart at (0,0) with that pixel;
  - no `frame_done` is issued;
  - published statistics are unchanged.
- `in_valid` low stalls the counters; gaps of any length are legal.
- Accumulators are cleared on frame start:
  - count = 0;
  - min_x = IMG_W-1, max_x = 0, min_y = IMG_H-1, max_y = 0;
  - any-skin flag = 0.
- For each skin pixel: count+1; min/max updated with the current x, y.
- Publish (DONE): `skin_count`, `bbox_*` and `bbox_valid` are loaded from the accumulators and held until the next publish.
  - If no skin was found: `bbox_valid` = 0 and all `bbox_*` = 0.
- `skin_count` cannot overflow: CW covers IMG_W*IMG_H.

## Timing
- Reset: every output is 0 and the FSM is in IDLE. A reset mid-frame discards the frame; statistics return to 0.
- Mask latency is 1 cycle: a pixel with `in_valid` at edge t gives `mask_valid`/`mask_bit`/`mask_x`/`mask_y` after edge t+1.
- `mask_valid` is 0 for pixels discarded in IDLE.
- Last pixel accepted at edge t: the last mask appears after t+1; `frame_done` is high for exactly one cycle after t+2, and the new statistics are visible in the same cycle.
- `in_valid & in_sof` during DONE is accepted as a new frame start (frame-to-frame back-to-back, zero gap). DONE still publishes the completed frame.
- No backpressure: the block always accepts input.

## Structure
- Package `skin_seg_pkg` holds:
  - the FSM state enum (IDLE, ACTIVE, DONE);
  - default threshold constants;
  - default IMG_W/IMG_H.
- Sub-module `skin_classifier`: purely combinational range compare (Y, Cb, Cr → skin), parameterised with the thresholds. The top level holds the FSM, counters, mask register and accumulators.

## Test plan
All scenarios use IMG_W=4, IMG_H=2 and default thresholds.
- Threshold edges:
  - (Y,Cb,Cr) = (100,77,133) → mask 1.
  - (100,127,173) → 1.
  - (100,128,150) → 0.
  - (100,100,174) → 0.
  - (39,100,150) → 0.
  - (40,100,150) → 1.
- Full frame with skin at (1,0), (3,0), (2,1) → `frame_done` 2 cycles after the last pixel; count 3; bbox x 1..3, y 0..1; `bbox_valid` 1.
- Frame with no skin → `frame_done`; count 0; `bbox_valid` 0; all bbox 0.
- `in_valid` gaps of 3 cycles between pixels → same statistics as the gap-free case; mask coordinates sequential 0..3, 0..1.
- Abort: `in_sof` after 5 pixels → no `frame_done` for the aborted frame; the next full frame's count reflects only its own pixels. Pixels before the first `in_sof` give no `mask_valid`.
- Async `rst` mid-frame → all outputs 0 immediately; the next `in_sof` frame completes normally.

Source files
------------

// File: rtl/skin_seg_pkg.sv
// Shared types and default parameters for the skin segmentation stage.
package skin_seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  localparam int unsigned DEF_IMG_W = 320;
  localparam int unsigned DEF_IMG_H = 240;

  localparam logic [7:0] DEF_Y_MIN  = 8'd40;
  localparam logic [7:0] DEF_CB_MIN = 8'd77;
  localparam logic [7:0] DEF_CB_MAX = 8'd127;
  localparam logic [7:0] DEF_CR_MIN = 8'd133;
  localparam logic [7:0] DEF_CR_MAX = 8'd173;

endpackage

// File: rtl/skin_classifier.sv
// Combinational YCbCr range test; all bounds inclusive, unsigned 8-bit.
module skin_classifier
  import skin_seg_pkg::*;
#(
  parameter logic [7:0] Y_MIN  = DEF_Y_MIN,
  parameter logic [7:0] CB_MIN = DEF_CB_MIN,
  parameter logic [7:0] CB_MAX = DEF_CB_MAX,
  parameter logic [7:0] CR_MIN = DEF_CR_MIN,
  parameter logic [7:0] CR_MAX = DEF_CR_MAX
) (
  input  logic [7:0] luma,
  input  logic [7:0] cb,
  input  logic [7:0] cr,
  output logic       skin
);

  always_comb begin
    skin = (luma >= Y_MIN) &&
           (cb >= CB_MIN) && (cb <= CB_MAX) &&
           (cr >= CR_MIN) && (cr <= CR_MAX);
  end

endmodule

// File: rtl/skin_segmenter.sv
// Skin mask stream plus per-frame skin count and bounding box statistics.
module skin_segmenter
  import skin_seg_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter logic [7:0]  Y_MIN  = DEF_Y_MIN,
  parameter logic [7:0]  CB_MIN = DEF_CB_MIN,
  parameter logic [7:0]  CB_MAX = DEF_CB_MAX,
  parameter logic [7:0]  CR_MIN = DEF_CR_MIN,
  parameter logic [7:0]  CR_MAX = DEF_CR_MAX
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic                             in_sof,
  input  logic [7:0]                       luma_ch,
  input  logic [7:0]                       cb_ch,
  input  logic [7:0]                       cr_ch,
  output logic                             mask_valid,
  output logic                             mask_bit,
  output logic [$clog2(IMG_W)-1:0]         mask_x,
  output logic [$clog2(IMG_H)-1:0]         mask_y,
  output logic                             frame_done,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] skin_count,
  output logic                             bbox_valid,
  output logic [$clog2(IMG_W)-1:0]         bbox_min_x,
  output logic [$clog2(IMG_W)-1:0]         bbox_max_x,
  output logic [$clog2(IMG_H)-1:0]         bbox_min_y,
  output logic [$clog2(IMG_H)-1:0]         bbox_max_y
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W * IMG_H + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  state_t         state;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [CW-1:0]  acc_count;
  logic [XW-1:0]  acc_min_x, acc_max_x;
  logic [YW-1:0]  acc_min_y, acc_max_y;
  logic           acc_any;

  logic           skin, start, accept, last;
  logic [XW-1:0]  px;
  logic [YW-1:0]  py;
  logic [CW-1:0]  n_count;
  logic [XW-1:0]  n_min_x, n_max_x;
  logic [YW-1:0]  n_min_y, n_max_y;
  logic           n_any;

  skin_classifier #(
    .Y_MIN (Y_MIN),
    .CB_MIN(CB_MIN),
    .CB_MAX(CB_MAX),
    .CR_MIN(CR_MIN),
    .CR_MAX(CR_MAX)
  ) u_classifier (
    .luma(luma_ch),
    .cb  (cb_ch),
    .cr  (cr_ch),
    .skin(skin)
  );

  // A start pixel is folded in against freshly cleared accumulators, so a
  // frame start and an abort-restart share one path.
  always_comb begin
    start  = in_valid && in_sof;
    accept = start || (in_valid && state == ACTIVE);
    px     = start ? '0 : x;
    py     = start ? '0 : y;
    last   = accept && (px == X_LAST) && (py == Y_LAST);

    n_count = start ? '0     : acc_count;
    n_min_x = start ? X_LAST : acc_min_x;
    n_max_x = start ? '0     : acc_max_x;
    n_min_y = start ? Y_LAST : acc_min_y;
    n_max_y = start ? '0     : acc_max_y;
    n_any   = start ? 1'b0   : acc_any;

    if (skin) begin
      n_count = n_count + 1'b1;
      n_min_x = (px < n_min_x) ? px : n_min_x;
      n_max_x = (px > n_max_x) ? px : n_max_x;
      n_min_y = (py < n_min_y) ? py : n_min_y;
      n_max_y = (py > n_max_y) ? py : n_max_y;
      n_any   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      acc_count  <= '0;
      acc_min_x  <= '0;
      acc_max_x  <= '0;
      acc_min_y  <= '0;
      acc_max_y  <= '0;
      acc_any    <= 1'b0;
      mask_valid <= 1'b0;
      mask_bit   <= 1'b0;
      mask_x     <= '0;
      mask_y     <= '0;
      frame_done <= 1'b0;
      skin_count <= '0;
      bbox_valid <= 1'b0;
      bbox_min_x <= '0;
      bbox_max_x <= '0;
      bbox_min_y <= '0;
      bbox_max_y <= '0;
    end else begin
      mask_valid <= accept;
      mask_bit   <= accept && skin;
      frame_done <= (state == DONE);

      if (state == DONE) begin
        skin_count <= acc_count;
        bbox_valid <= acc_any;
        bbox_min_x <= acc_any ? acc_min_x : '0;
        bbox_max_x <= acc_any ? acc_max_x : '0;
        bbox_min_y <= acc_any ? acc_min_y : '0;
        bbox_max_y <= acc_any ? acc_max_y : '0;
      end

      if (accept) begin
        mask_x    <= px;
        mask_y    <= py;
        acc_count <= n_count;
        acc_min_x <= n_min_x;
        acc_max_x <= n_max_x;
        acc_min_y <= n_min_y;
        acc_max_y <= n_max_y;
        acc_any   <= n_any;
        if (px == X_LAST) begin
          x <= '0;
          y <= (py == Y_LAST) ? '0 : py + 1'b1;
        end else begin
          x <= px + 1'b1;
          y <= py;
        end
        state <= last ? DONE : ACTIVE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule
